// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler that owns the select and strobe lines of BLOCKS
// 4-input muxes sharing one select bus.
//
// Parameters:
//   BLOCKS    number of mux blocks strobed together by Enable_bar
//   HOLD_MAX  maximum consecutive cycles a single grant may last (1..256)
//
// Ports:
//   clk         clock, all state changes on its rising edge
//   reset       synchronous active-high reset
//   req[3:0]    per-channel request for the shared path
//   grant[3:0]  one-hot owner of the path, or zero
//   Select[1:0] mux select lines
//   Enable_bar  active-low mux strobes, one per block
//   busy        high while a grant is active
//
// All outputs are registered. Select only moves on an edge leaving IDLE or
// GUARD, where the strobes were already high, so the mux never sees a select
// change while enabled.
module mux4_rr_scheduler #(
  parameter int unsigned BLOCKS   = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  output logic [3:0]        grant,
  output logic [1:0]        Select,
  output logic [BLOCKS-1:0] Enable_bar,
  output logic              busy
);

  localparam int unsigned CntW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGuard
  } state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] cnt_q;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Search ptr, ptr+1, ptr+2, ptr+3; iterating from the far end lets the
  // nearest asserted request overwrite the farther ones.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select doubles as the index of the current owner while in StGrant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      cnt_q      <= '0;
      grant      <= 4'b0000;
      Select     <= 2'd0;
      Enable_bar <= '1;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StGuard: begin
          if (win_valid) begin
            state_q    <= StGrant;
            Select     <= win_idx;
            grant      <= 4'b0001 << win_idx;
            Enable_bar <= '0;
            busy       <= 1'b1;
            cnt_q      <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (req[Select] && (cnt_q < CntLast)) begin
            cnt_q <= cnt_q + CntW'(1);
          end else begin
            // Released or timed out: owner drops to lowest priority.
            state_q    <= StGuard;
            ptr_q      <= Select + 2'd1;
            grant      <= 4'b0000;
            Enable_bar <= '1;
            busy       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
